// File: rtl/rsp_s2_dma_axi_err_ctrl.sv
// AXI error controller for the rsp_s2 DMA master: aborts on the first error, drains
// outstanding transactions under a bounded timeout, then halts with sticky status.
module rsp_s2_dma_axi_err_ctrl #(
    parameter int NUM_SRC    = 5,
    parameter int OST_BITS   = 6,
    parameter int DRAIN_BITS = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_SRC-1:0]    timeout_in,
    input  logic                  rresp_err,
    input  logic                  bresp_err,
    input  logic [OST_BITS-1:0]   ost_cnt,
    input  logic                  err_clr,
    input  logic                  err_irq_en,
    output logic                  dma_abort,
    output logic                  err_active,
    output logic                  err_irq,
    output logic [NUM_SRC+1:0]    err_src,
    output logic [2:0]            err_first,
    output logic [7:0]            err_cnt,
    output logic                  drain_fail
);
    localparam int EV_W = NUM_SRC + 2;

    typedef enum logic [1:0] {IDLE, ABORT, DRAIN, HALT} state_t;

    state_t                state;
    logic [NUM_SRC-1:0]    to_prev;
    logic [DRAIN_BITS-1:0] drain_cnt;
    logic [EV_W-1:0]       ev_vec;
    logic                  any_ev;
    logic [2:0]            ev_first;
    logic                  clr_hit;

    // Timeouts are levels; only the rising edge is an event.
    always_comb begin
        ev_vec = {bresp_err, rresp_err, timeout_in & ~to_prev};
        any_ev = |ev_vec;
    end

    always_comb begin
        ev_first = '0;
        for (int i = EV_W - 1; i >= 0; i--)
            if (ev_vec[i]) ev_first = 3'(i);
    end

    assign clr_hit    = (state == HALT) && err_clr;
    assign dma_abort  = (state != IDLE);
    assign err_active = (state == HALT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            to_prev    <= '0;
            drain_cnt  <= '0;
            err_irq    <= 1'b0;
            err_src    <= '0;
            err_first  <= '0;
            err_cnt    <= '0;
            drain_fail <= 1'b0;
        end else begin
            to_prev <= timeout_in;
            if (clr_hit) begin
                // Clear beats a coincident event; that event is dropped.
                state      <= IDLE;
                err_irq    <= 1'b0;
                err_src    <= '0;
                err_first  <= '0;
                err_cnt    <= '0;
                drain_fail <= 1'b0;
            end else begin
                err_src <= err_src | ev_vec;
                if (any_ev && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                case (state)
                    IDLE: begin
                        if (any_ev) begin
                            err_first <= ev_first;
                            state     <= ABORT;
                        end
                    end
                    ABORT: begin
                        drain_cnt <= '1;
                        state     <= DRAIN;
                    end
                    DRAIN: begin
                        if (ost_cnt == '0) begin
                            state <= HALT;
                            if (err_irq_en) err_irq <= 1'b1;
                        end else if (drain_cnt == '0) begin
                            drain_fail <= 1'b1;
                            state      <= HALT;
                            if (err_irq_en) err_irq <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt - DRAIN_BITS'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rsp_s2_dma_axi_err_ctrl.sv
// Scoreboard bench: a behavioural model predicts every cycle's outputs; a monitor compares.
module tb_rsp_s2_dma_axi_err_ctrl;
    logic       clk = 0;
    logic       rst_n = 0;
    logic [4:0] timeout_in = '0;
    logic       rresp_err = 0, bresp_err = 0, err_clr = 0, err_irq_en = 0;
    logic [5:0] ost_cnt = '0;
    logic       dma_abort, err_active, err_irq, drain_fail;
    logic [6:0] err_src;
    logic [2:0] err_first;
    logic [7:0] err_cnt;

    rsp_s2_dma_axi_err_ctrl dut (
        .clk(clk), .rst_n(rst_n), .timeout_in(timeout_in), .rresp_err(rresp_err),
        .bresp_err(bresp_err), .ost_cnt(ost_cnt), .err_clr(err_clr), .err_irq_en(err_irq_en),
        .dma_abort(dma_abort), .err_active(err_active), .err_irq(err_irq), .err_src(err_src),
        .err_first(err_first), .err_cnt(err_cnt), .drain_fail(drain_fail)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       abort;
        logic       active;
        logic       irq;
        logic [6:0] src;
        logic [2:0] first;
        logic [7:0] cnt;
        logic       fail;
    } obs_t;

    obs_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: phase 0 idle, 1 abort, 2 drain, 3 halt.
    int         m_phase = 0;
    int         m_drain_cycles = 0;
    logic [4:0] m_prev = '0;
    logic [6:0] m_src = '0;
    int         m_first = 0;
    int         m_cnt = 0;
    bit         m_fail = 0, m_irq = 0;

    task automatic model_step();
        logic [6:0] ev;
        obs_t       e;
        if (!rst_n) begin
            m_phase = 0; m_drain_cycles = 0; m_prev = '0; m_src = '0;
            m_first = 0; m_cnt = 0; m_fail = 0; m_irq = 0;
        end else begin
            ev = {bresp_err, rresp_err, timeout_in & ~m_prev};
            m_prev = timeout_in;
            if (m_phase == 3 && err_clr) begin
                m_phase = 0; m_src = '0; m_first = 0; m_cnt = 0; m_fail = 0; m_irq = 0;
            end else begin
                m_src = m_src | ev;
                if (ev != 0) m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
                if (m_phase == 0) begin
                    if (ev != 0) begin
                        for (int i = 6; i >= 0; i--) if (ev[i]) m_first = i;
                        m_phase = 1;
                    end
                end else if (m_phase == 1) begin
                    m_phase = 2;
                    m_drain_cycles = 0;
                end else if (m_phase == 2) begin
                    // Drain window is 1024 cycles; the last one gives up if still busy.
                    if (ost_cnt == 0 || m_drain_cycles == 1023) begin
                        if (ost_cnt != 0) m_fail = 1;
                        m_phase = 3;
                        if (err_irq_en) m_irq = 1;
                    end else m_drain_cycles++;
                end
            end
        end
        e.abort = (m_phase != 0);
        e.active = (m_phase == 3);
        e.irq = m_irq;
        e.src = m_src;
        e.first = 3'(m_first);
        e.cnt = 8'(m_cnt);
        e.fail = m_fail;
        q.push_back(e);
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    always @(negedge clk) begin
        obs_t e, a;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = '{dma_abort, err_active, err_irq, err_src, err_first, err_cnt, drain_fail};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL cycle_obs t=%0t got abort=%b act=%b irq=%b src=%b first=%0d cnt=%0d fail=%b want abort=%b act=%b irq=%b src=%b first=%0d cnt=%0d fail=%b",
                         $time, a.abort, a.active, a.irq, a.src, a.first, a.cnt, a.fail,
                         e.abort, e.active, e.irq, e.src, e.first, e.cnt, e.fail);
            end
        end
    end

    task automatic clear_halt();
        err_clr = 1; tick(); err_clr = 0; tick();
    endtask

    initial begin
        @(negedge clk); #2;
        rst_n = 0; ticks(2); rst_n = 1;

        // Drain succeeds.
        err_irq_en = 1; ost_cnt = 3; ticks(2);
        timeout_in[1] = 1; tick();
        ticks(4); ost_cnt = 0; ticks(3);
        timeout_in[1] = 0; clear_halt();

        // Simultaneous errors, later rresp during drain.
        ost_cnt = 2; bresp_err = 1; timeout_in[3] = 1; tick();
        bresp_err = 0; ticks(2);
        rresp_err = 1; tick(); rresp_err = 0;
        ticks(2); ost_cnt = 0; ticks(2);
        timeout_in[3] = 0; clear_halt();

        // Drain fails with interrupts disabled.
        err_irq_en = 0; ost_cnt = 5; rresp_err = 1; tick(); rresp_err = 0;
        ticks(1030);
        err_clr = 1; bresp_err = 1; tick(); err_clr = 0; bresp_err = 0; ticks(2);

        // Held level counts once.
        ost_cnt = 0; timeout_in[0] = 1; ticks(50); timeout_in[0] = 0;
        ticks(3); clear_halt();

        // Saturation, with a clear attempt while draining.
        ost_cnt = 5; err_irq_en = 1;
        for (int i = 0; i < 300; i++) begin
            rresp_err = 1; err_clr = (i == 10); tick();
        end
        rresp_err = 0; err_clr = 0; ost_cnt = 0; ticks(3); clear_halt();

        // Reset mid-drain.
        ost_cnt = 4; bresp_err = 1; tick(); bresp_err = 0; ticks(5);
        rst_n = 0; tick(); rst_n = 1; ticks(3);

        // Timeout already high at reset release.
        timeout_in[2] = 1; rst_n = 0; tick(); rst_n = 1; ost_cnt = 0; ticks(4);
        timeout_in[2] = 0; clear_halt();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 5; b++)
                if ($urandom_range(0, 19) == 0) timeout_in[b] = ~timeout_in[b];
            rresp_err  = ($urandom_range(0, 29) == 0);
            bresp_err  = ($urandom_range(0, 39) == 0);
            err_clr    = ($urandom_range(0, 14) == 0);
            err_irq_en = $urandom_range(0, 1);
            ost_cnt    = 6'($urandom_range(0, 3));
            rst_n      = ($urandom_range(0, 299) != 0);
            tick();
        end
        rst_n = 1; rresp_err = 0; bresp_err = 0; err_clr = 0;

        @(negedge clk); @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
